// File: rtl/nn_pkg.sv
// nn_pkg: shared scan-state type and default output-layer geometry for argmax decoder and label encoder
package nn_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int NN_NUM_CLASSES = 10;
  localparam int NN_DATA_W = 16;
endpackage

// File: rtl/onehot_check.sv
// onehot_check: err=1 unless exactly one bit of vec is set (vec: label in, err: flag out)
module onehot_check #(
  parameter int N = 10
) (
  input  logic [N-1:0] vec,
  output logic         err
);
  assign err = $countones(vec) != 1;
endmodule

// File: rtl/output_argmax_decoder.sv
// output_argmax_decoder: streams signed class activations, reports argmax/max vs one-hot label (start/label/in_* in; in_ready, out_*, pred_*, correct, label_err, correct_cnt out)
module output_argmax_decoder
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NN_NUM_CLASSES,
  parameter int DATA_W = NN_DATA_W,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_vals_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic [NUM_CLASSES-1:0]         label,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] pred_index,
  output logic [DATA_W-1:0]              pred_max,
  output logic                           correct,
  output logic                           label_err,
  output logic [CNT_W-1:0]               correct_cnt
);
  localparam int IW = $clog2(NUM_CLASSES);
  state_t state, next;
  logic [IW-1:0] idx, max_idx;
  logic signed [DATA_W-1:0] max_reg;
  logic [NUM_CLASSES-1:0] label_reg;
  logic err_reg, err_c, accept, last;
  onehot_check #(.N(NUM_CLASSES)) u_chk (.vec(label), .err(err_c));
  assign accept = state == SCAN && in_valid;
  assign last = idx == IW'(NUM_CLASSES - 1);
  assign in_ready = state == SCAN;
  assign out_valid = state == DONE;
  assign pred_index = max_idx;
  assign pred_max = max_reg;
  assign label_err = err_reg;
  assign correct = label_reg[max_idx] && !err_reg;
  always_comb begin
    next = state;
    if (state == IDLE && start) next = SCAN;
    if (accept && last) next = DONE;
    if (state == DONE && out_ready) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_vals_n) begin
    if (!rst_vals_n) begin
      state <= IDLE;
      idx <= '0;
      max_idx <= '0;
      max_reg <= '0;
      label_reg <= '0;
      err_reg <= 1'b0;
      correct_cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        idx <= '0;
        label_reg <= label;
        err_reg <= err_c;
      end
      if (accept) begin
        idx <= last ? idx : idx + 1'b1;
        if (idx == '0 || $signed(in_data) > max_reg) begin
          max_reg <= $signed(in_data);
          max_idx <= idx;
        end
      end
      if (state == DONE && out_ready && correct && !(&correct_cnt)) correct_cnt <= correct_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_output_argmax_decoder.sv
// tb_output_argmax_decoder: randomized self-checking bench against a plain argmax reference model
module tb_output_argmax_decoder;
  logic clk = 0, rst_vals_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic [9:0] label = '0;
  logic in_ready, out_valid, correct, label_err;
  logic in_ready2, out_valid2, correct2, label_err2;
  logic [3:0] pred_index, pred_index2;
  logic [15:0] pred_max, pred_max2, correct_cnt;
  logic [1:0] correct_cnt2;
  int act [10];
  int n_tests = 0, n_fail = 0, model_cnt = 0;
  always #5 clk = ~clk;
  output_argmax_decoder u_dut (
    .clk(clk), .rst_vals_n(rst_vals_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .label(label), .out_valid(out_valid), .out_ready(out_ready),
    .pred_index(pred_index), .pred_max(pred_max), .correct(correct), .label_err(label_err),
    .correct_cnt(correct_cnt)
  );
  output_argmax_decoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_vals_n(rst_vals_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .label(label), .out_valid(out_valid2), .out_ready(out_ready),
    .pred_index(pred_index2), .pred_max(pred_max2), .correct(correct2), .label_err(label_err2),
    .correct_cnt(correct_cnt2)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_result(input string pfx, input int mi, input bit e_err, input bit e_ok);
    check({pfx, "out_valid"}, int'(out_valid), 1);
    check({pfx, "pred_index"}, int'(pred_index), mi);
    check({pfx, "pred_max"}, int'($signed(pred_max)), act[mi]);
    check({pfx, "correct"}, int'(correct), int'(e_ok));
    check({pfx, "label_err"}, int'(label_err), int'(e_err));
  endtask
  task automatic run_scan(input logic [9:0] lbl, input bit stall, input int hold, input bit start_on_hs);
    int mi;
    bit e_err, e_ok;
    mi = 0;
    for (int i = 1; i < 10; i++) if (act[i] > act[mi]) mi = i;
    e_err = $countones(lbl) != 1;
    e_ok = !e_err && lbl[mi];
    @(negedge clk);
    start = 1;
    label = lbl;
    @(negedge clk);
    start = 0;
    label = 10'($urandom);
    for (int i = 0; i < 10; i++) begin
      if (stall) begin
        in_valid = 0;
        in_data = 16'h7fff;
        @(negedge clk);
      end
      in_valid = 1;
      in_data = act[i][15:0];
      check("in_ready_scan", int'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 0;
    check_result("", mi, e_err, e_ok);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1;
      in_data = 16'h7fff;
      start = 1;
      @(negedge clk);
      check_result("stall_", mi, e_err, e_ok);
    end
    in_valid = 0;
    start = start_on_hs;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    start = 0;
    if (e_ok) model_cnt++;
    check("out_valid_after_hs", int'(out_valid), 0);
    check("in_ready_after_hs", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 0);
    check("correct_cnt", int'(correct_cnt), model_cnt);
    check("correct_cnt_sat", int'(correct_cnt2), model_cnt > 3 ? 3 : model_cnt);
  endtask
  initial begin
    int mi;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_cnt", int'(correct_cnt), 0);
    @(negedge clk);
    rst_vals_n = 1;
    act = '{3, -1, 7, 2, 0, 5, 7, -4, 1, 6};
    run_scan(10'b0000000100, 0, 0, 0);
    for (int i = 0; i < 10; i++) act[i] = -5;
    run_scan(10'b0000000001, 0, 1, 1);
    @(negedge clk);
    start = 1;
    label = 10'b0000000001;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = 16'(i + 20);
      @(negedge clk);
    end
    rst_vals_n = 0;
    #1;
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_pred_index", int'(pred_index), 0);
    check("arst_pred_max", int'(pred_max), 0);
    check("arst_correct", int'(correct), 0);
    check("arst_label_err", int'(label_err), 0);
    check("arst_cnt", int'(correct_cnt), 0);
    check("arst_cnt_sat", int'(correct_cnt2), 0);
    in_valid = 0;
    model_cnt = 0;
    @(negedge clk);
    rst_vals_n = 1;
    act = '{1, 2, 3, 4, 9, 5, 6, 7, 8, 0};
    run_scan(10'b0000010000, 0, 0, 0);
    act = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    run_scan(10'b1000000000, 1, 4, 0);
    run_scan(10'b0000000000, 0, 0, 0);
    run_scan(10'b0000010010, 0, 2, 0);
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 10; i++) act[i] = int'($urandom_range(0, 15)) - 8;
      mi = 0;
      for (int i = 1; i < 10; i++) if (act[i] > act[mi]) mi = i;
      run_scan(t < 4 ? 10'(1 << mi) : (t % 3 == 0 ? 10'($urandom) : 10'(1 << $urandom_range(0, 9))),
               t[0], t % 3, t[1]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/output_argmax_decoder.md
OUTPUT_ARGMAX_DECODER -- requirements
Module: output_argmax_decoder

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of output-layer neurons (classes).
REQ-002 SHALL have parameter DATA_W, default 16, width of one signed activation.
REQ-003 SHALL have parameter CNT_W, default 16, width of the correct-prediction counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_vals_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begins a new scan; sampled only in IDLE.
REQ-007 SHALL have port in_valid  input  1  in_data carries an activation.
REQ-008 SHALL have port in_ready  output  1  high only in SCAN.
REQ-009 SHALL have port in_data  input  DATA_W  signed activation, classes presented in order 0..NUM_CLASSES-1.
REQ-010 SHALL have port label  input  NUM_CLASSES  one-hot training label, bit 0 = class 0, sampled on the start beat.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port pred_index  output  $clog2(NUM_CLASSES)  argmax class index.
REQ-014 SHALL have port pred_max  output  DATA_W  winning signed activation.
REQ-015 SHALL have port correct  output  1  pred_index matches the sampled label.
REQ-016 SHALL have port label_err  output  1  sampled label not exactly one-hot.
REQ-017 SHALL have port correct_cnt  output  CNT_W  running count of correct predictions.

Function
REQ-018 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE on the beat accepting class NUM_CLASSES-1, DONE->IDLE on out_valid&&out_ready.
REQ-019 SHALL accept a beat when in_valid&&in_ready; in_valid low stalls the scan without changing state.
REQ-020 SHALL load the first accepted beat unconditionally as running max with index 0.
REQ-021 SHALL replace the running max only when in_data is strictly greater (signed), so ties keep the lowest index.
REQ-022 SHALL count beats with an internal index counter that clears on start and never exceeds NUM_CLASSES-1.
REQ-023 SHALL assert out_valid in the cycle after the last beat is accepted, holding pred_index, pred_max, correct and label_err stable until the handshake completes.
REQ-024 SHALL compute correct = label_reg[pred_index] && !label_err.
REQ-025 SHALL set label_err when the sampled label has zero or more than one bit set.
REQ-026 SHALL increment correct_cnt by one on each completed output handshake with correct=1, saturating at all-ones.
REQ-027 SHALL ignore start outside IDLE, and SHALL ignore in_valid outside SCAN.
REQ-028 SHALL allow start in the same cycle as the DONE->IDLE handshake to be ignored; start is honoured only in the following IDLE cycle.

Reset
REQ-029 SHALL on rst_vals_n low asynchronously force state IDLE, in_ready 0, out_valid 0, pred_index 0, pred_max 0, correct 0, label_err 0, correct_cnt 0, index counter 0.
REQ-030 SHALL on reset mid-SCAN or mid-DONE discard the partial result and leave correct_cnt at 0.
REQ-031 SHALL deassert reset synchronously externally; first active edge after release is an IDLE cycle.

Structure
REQ-032 SHALL take the state enum type and default NUM_CLASSES/DATA_W values from a shared package nn_pkg, shared with the label encoder.
REQ-033 SHALL include one sub-module onehot_check (combinational popcount==1 check for label_err); everything else is in one module.

Verification
REQ-034 SHALL cover: activations 3,-1,7,2,0,5,7,-4,1,6 with label bit 2 -> pred_index 2, pred_max 7, correct 1, correct_cnt 1.
REQ-035 SHALL cover: all ten activations -5 -> pred_index 0 (tie keeps lowest), pred_max -5.
REQ-036 SHALL cover: max at class 9 with in_valid toggling every other cycle and out_ready held low 4 cycles -> pred_index 9, outputs stable throughout the stall.
REQ-037 SHALL cover: label 0 and label with bits 1 and 4 set -> label_err 1, correct 0, correct_cnt unchanged.
REQ-038 SHALL cover: rst_vals_n pulsed low after 5 beats -> all outputs 0 immediately; a new full scan then completes correctly.
REQ-039 SHALL cover: CNT_W=2 with five correct predictions -> correct_cnt saturates at 3.
